// File: rtl/overcooked_pkg.sv
// Shared types and screen constants for the overcooked render/control blocks.
//   xcoord_t / ycoord_t : pixel coordinate types (11-bit x, 10-bit y)
//   SCREEN_X_MAX/Y_MAX  : largest visible coordinate on each axis
//   slide_state_t       : position-controller FSM states
package overcooked_pkg;

    typedef logic [10:0] xcoord_t;
    typedef logic [9:0]  ycoord_t;

    localparam int SCREEN_X_MAX = 1023;
    localparam int SCREEN_Y_MAX = 767;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SLIDE   = 2'd2
    } slide_state_t;

endpackage

// File: rtl/axis_stepper.sv
// One-axis slide step, purely combinational.
//   pos_in       : current committed coordinate
//   target_in    : coordinate being approached
//   next_pos_out : pos moved toward target by min(STEP, |target - pos|)
//   at_target_out: pos already equals target
module axis_stepper #(
    parameter int WIDTH = 11,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0] pos_in,
    input  logic [WIDTH-1:0] target_in,
    output logic [WIDTH-1:0] next_pos_out,
    output logic             at_target_out
);

    localparam logic signed [WIDTH:0] STEP_S = $signed((WIDTH+1)'(STEP));
    localparam logic [WIDTH-1:0]      STEP_U = WIDTH'(STEP);

    // One extra bit keeps the full +/- range of the difference representable.
    logic signed [WIDTH:0] diff;
    assign diff = $signed({1'b0, target_in}) - $signed({1'b0, pos_in});

    // Within one step of the target we land on it exactly, so no overshoot
    // and no wrap as long as the target itself is in range.
    always_comb begin
        next_pos_out = target_in;
        if (diff > STEP_S)
            next_pos_out = pos_in + STEP_U;
        else if (diff < -STEP_S)
            next_pos_out = pos_in - STEP_U;
    end

    assign at_target_out = (pos_in == target_in);

endmodule

// File: rtl/counter_slide_ctrl.sv
// Position controller for one counter-table render instance.
// Latches a placement request and commits it only on a frame tick, either as
// a single jump (snap) or as a per-frame slide, so x_out/y_out never change
// mid-frame.
//   clk_in, rst_n_in          : pixel clock, async active-low reset
//   hcount_in, vcount_in      : raster position (frame tick at 0,0)
//   req_valid/ready, req_x/y, req_snap : placement request handshake
//   x_out, y_out              : committed position to the renderer
//   moving_out                : request pending or slide in progress
//   done_out                  : one-cycle pulse with the final position
module counter_slide_ctrl
    import overcooked_pkg::*;
#(
    parameter int X_MAX  = SCREEN_X_MAX,
    parameter int Y_MAX  = SCREEN_Y_MAX,
    parameter int STEP   = 4,
    parameter int INIT_X = 0,
    parameter int INIT_Y = 0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic [10:0] req_x_in,
    input  logic [9:0]  req_y_in,
    input  logic        req_snap_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        moving_out,
    output logic        done_out
);

    localparam xcoord_t X_LIM = xcoord_t'(X_MAX);
    localparam ycoord_t Y_LIM = ycoord_t'(Y_MAX);
    localparam xcoord_t X_RST = xcoord_t'(INIT_X);
    localparam ycoord_t Y_RST = ycoord_t'(INIT_Y);

    slide_state_t state_q, state_d;
    xcoord_t      x_q, x_d, tx_q, tx_d, x_nxt;
    ycoord_t      y_q, y_d, ty_q, ty_d, y_nxt;
    logic         snap_q, snap_d;
    logic         done_q, done_d;
    logic         zero_q, zero_d;
    logic         x_at, y_at, tick;

    // Rising edge of "raster at (0,0)": one tick per frame even if the
    // origin is held for several cycles.
    assign zero_d = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign tick   = zero_d && !zero_q;

    axis_stepper #(.WIDTH(11), .STEP(STEP)) u_x_step (
        .pos_in       (x_q),
        .target_in    (tx_q),
        .next_pos_out (x_nxt),
        .at_target_out(x_at)
    );

    axis_stepper #(.WIDTH(10), .STEP(STEP)) u_y_step (
        .pos_in       (y_q),
        .target_in    (ty_q),
        .next_pos_out (y_nxt),
        .at_target_out(y_at)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        snap_d  = snap_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_in) begin
                    tx_d    = (req_x_in > X_LIM) ? X_LIM : req_x_in;
                    ty_d    = (req_y_in > Y_LIM) ? Y_LIM : req_y_in;
                    snap_d  = req_snap_in;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (tick) begin
                    if (snap_q || (x_at && y_at)) begin
                        x_d     = tx_q;
                        y_d     = ty_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        x_d = x_nxt;
                        y_d = y_nxt;
                        // A short slide can finish on its very first step.
                        if (x_nxt == tx_q && y_nxt == ty_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = SLIDE;
                        end
                    end
                end
            end
            SLIDE: begin
                if (tick) begin
                    x_d = x_nxt;
                    y_d = y_nxt;
                    if (x_nxt == tx_q && y_nxt == ty_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            x_q     <= X_RST;
            y_q     <= Y_RST;
            tx_q    <= X_RST;
            ty_q    <= Y_RST;
            snap_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            snap_q  <= snap_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
        end
    end

    assign req_ready_out = (state_q == IDLE);
    assign moving_out    = (state_q != IDLE);
    assign x_out         = x_q;
    assign y_out         = y_q;
    assign done_out      = done_q;

endmodule

// File: doc/counter_slide_ctrl.md
# counter_slide_ctrl

Position controller for one counter-table render instance. Game logic requests a new (x, y) placement through a valid/ready handshake. The block latches the request and commits it only at frame start, either in one jump or as a per-frame slide, so the table renderer's x_in/y_in never change mid-frame. It sits between the game-state logic and the table renderer's position inputs, in the pixel-clock domain.

## Interface

Clock is single, `clk_in`. Reset `rst_n_in` is asynchronous and active-low.

Parameters:
- X_MAX, 1023: largest legal x coordinate; requests are clamped to it.
- Y_MAX, 767: largest legal y coordinate; requests are clamped to it.
- STEP, 4: pixels moved per axis per frame while sliding (1..63).
- INIT_X, 0: x position after reset.
- INIT_Y, 0: y position after reset.

Ports:
- clk_in, input, 1: pixel clock.
- rst_n_in, input, 1: asynchronous active-low reset.
- hcount_in, input, 11: current pixel column.
- vcount_in, input, 10: current pixel row.
- req_valid_in, input, 1: placement request valid.
- req_ready_out, output, 1: block can accept a request.
- req_x_in, input, 11: requested x.
- req_y_in, input, 10: requested y.
- req_snap_in, input, 1: 1 means jump at the next frame start; 0 means slide.
- x_out, output, 11: committed x, drives the renderer's x_in.
- y_out, output, 10: committed y, drives the renderer's y_in.
- moving_out, output, 1: a request is pending or a slide is in progress.
- done_out, output, 1: one-cycle pulse when the target is reached.

## Operation

- Frame tick:
  - tick = (hcount_in==0 && vcount_in==0) && the previous cycle was not (0,0).
  - This requires a registered flag.
  - Holding (0,0) for several cycles yields exactly one tick.
- States are IDLE, PENDING and SLIDE.
- IDLE:
  - req_ready_out=1.
  - On valid&&ready, latch tx=min(req_x_in,X_MAX), ty=min(req_y_in,Y_MAX) and snap, then go to PENDING.
- PENDING, on tick:
  - If snap, or target equals current position: load x_out=tx, y_out=ty, pulse done_out, go to IDLE.
  - Otherwise apply one step and go to SLIDE. If that step reaches the target, pulse done_out and go to IDLE instead.
- SLIDE, on tick:
  - Each axis moves toward its target by min(STEP, |target−pos|).
  - Neither axis overshoots, and each axis moves independently.
  - When both axes equal the target: pulse done_out and go to IDLE.
- Differences are computed one bit wider than the coordinate, signed.
- Outputs never wrap and never leave [0, X_MAX] × [0, Y_MAX].
- req_ready_out=0 in PENDING and SLIDE. Requests then are not accepted and not queued; the requester holds valid.
- moving_out=1 exactly in PENDING and SLIDE.
- Reset (asynchronous, any state, including mid-slide):
  - x_out=INIT_X, y_out=INIT_Y.
  - State IDLE, req_ready_out=1, moving_out=0, done_out=0.
  - Tick-history flag cleared, so (0,0) in the first cycle after reset produces a tick.

## Timing

- Request accepted at clock edge E. From the cycle after E: ready=0 and moving_out=1.
- A tick seen in the same cycle as acceptance is not used; the commit waits for the next tick.
- Position update: on the edge ending the tick cycle. x_out and y_out are registered and change only on those edges.
- done_out:
  - High for exactly one cycle: the first cycle showing the final position.
  - In that same cycle state is IDLE, ready=1 and moving_out=0.
  - A new request can be accepted in that cycle.
- Snap latency is acceptance plus the next tick plus 1 cycle.
- Slide takes ceil(max(|dx|,|dy|)/STEP) ticks.

## Structure

- Shared package `overcooked_pkg`:
  - typedefs `xcoord_t` (logic [10:0]) and `ycoord_t` (logic [9:0]).
  - screen constants `SCREEN_X_MAX`, `SCREEN_Y_MAX`.
  - enum `slide_state_t` {IDLE, PENDING, SLIDE}.
- Sub-module `axis_stepper` (parameter WIDTH):
  - Combinational: given pos, target and STEP, outputs next_pos and at_target.
  - Instantiated twice, once for x and once for y.
- Top level holds the FSM, the tick detector and the target/position registers.

## Test plan

- Reset: assert rst_n_in=0 mid-cycle → immediately x_out=0, y_out=0, ready=1, moving_out=0, done_out=0.
- Snap: request (200,100), snap=1 → x_out stays 0 until the tick; the edge after the tick gives (200,100); done_out high 1 cycle; ready=1.
- Slide (STEP=4, from (0,0)): request (10,3), snap=0 → positions after successive ticks (4,3), (8,3), (10,3); done_out with the third; moving_out high throughout.
- Clamp and backpressure:
  - Request (2000,900) → target (1023,767).
  - While moving, hold valid with (5,5) → not accepted.
  - It is accepted in the done_out cycle.
- Tick edge detect: hold hcount_in=vcount_in=0 for 5 cycles during a slide → exactly one step.
- Reset mid-slide: pulse rst_n_in low after 2 ticks of a (100,0) slide → (INIT_X,INIT_Y), IDLE; no done_out pulse.
